cpu_mc: RTL and testbench

- Parametrised second-generation multi-cycle 8-bit CPU.
- Fetches 32-bit instructions, MSB first, over a byte-wide memory bus that has a req/ready handshake, so memories with wait states are supported.
- Adds three things over the first generation: a configurable register-file depth, Z/C flags with conditional jumps, and an explicit halted state.
- Sits between the top level and the shared instruction/data RAM.

---
 rtl/cpu_mc_pkg.sv | 38 +++
 rtl/cpu_mc_alu.sv | 43 ++++
 rtl/cpu_mc.sv | 206 ++++++++++++++++++++
 tb/tb_cpu_mc.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mc_pkg.sv
// Shared definitions for the multi-cycle 8-bit CPU: opcodes, FSM states and defaults.
package cpu_mc_pkg;

    typedef enum logic [7:0] {
        OP_HALT = 8'h00,
        OP_LD   = 8'h01,
        OP_ST   = 8'h02,
        OP_LDI  = 8'h03,
        OP_MOV  = 8'h04,
        OP_ADD  = 8'h05,
        OP_SUB  = 8'h06,
        OP_AND  = 8'h07,
        OP_OR   = 8'h08,
        OP_XOR  = 8'h09,
        OP_ROTL = 8'h0A,
        OP_ROTR = 8'h0B,
        OP_JMP  = 8'h0C,
        OP_JZ   = 8'h0D,
        OP_JNZ  = 8'h0E,
        OP_JC   = 8'h0F
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_EXEC   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [15:0] RESET_VECTOR_DEF = 16'h0000;

    // Only ALU opcodes produce a result that updates Z/C.
    function automatic logic is_alu_op(input logic [7:0] op);
        return (op >= OP_ADD) && (op <= OP_ROTR);
    endfunction

endpackage

// File: rtl/cpu_mc_alu.sv
// Combinational 8-bit ALU: arithmetic, logic and rotates with zero/carry flags.
module cpu_alu
    import cpu_mc_pkg::*;
(
    input  logic [7:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] result,
    output logic       z,
    output logic       c
);

    logic [8:0] sum;
    logic [2:0] amt;
    logic [3:0] amt_inv;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        amt     = b[2:0];
        // A shift by 8 of an 8-bit value is 0, so amount 0 passes a through.
        amt_inv = 4'd8 - {1'b0, amt};
        result  = 8'h00;
        c       = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[7:0];
                c      = sum[8];
            end
            OP_SUB: begin
                result = a - b;
                c      = (a < b);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ROTL: result = (a << amt) | (a >> amt_inv);
            OP_ROTR: result = (a >> amt) | (a << amt_inv);
            default: result = 8'h00;
        endcase
        z = (result == 8'h00);
    end

endmodule

// File: rtl/cpu_mc.sv
// Multi-cycle 8-bit CPU: byte-serial 32-bit instruction fetch over a req/ready bus,
// register file of REGS entries, Z/C flags, conditional jumps and a halted state.
module cpu_mc
    import cpu_mc_pkg::*;
#(
    parameter int          REGS         = 256,
    parameter int          ADDR_W       = 16,
    parameter logic [15:0] RESET_VECTOR = RESET_VECTOR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic              mem_ready,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    localparam int                RI_W = $clog2(REGS);
    localparam logic [ADDR_W-1:0] RV   = RESET_VECTOR[ADDR_W-1:0];

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       ir_q, ir_d;
    logic              z_q, z_d, c_q, c_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              halted_q, halted_d;

    logic [7:0]        rf_q [REGS];
    logic              rf_we;
    logic [RI_W-1:0]   rf_waddr;
    logic [7:0]        rf_wdata;

    logic [7:0]        opcode;
    logic [RI_W-1:0]   d_idx, a_idx, b_idx;
    logic [7:0]        rd_val, ra_val, rb_val;
    logic [ADDR_W-1:0] addr16, jaddr, pc_next4;
    logic [4:0]        byte_lsb;
    logic [7:0]        alu_res;
    logic              alu_z, alu_c;

    assign opcode   = ir_q[31:24];
    assign d_idx    = ir_q[16 +: RI_W];
    assign a_idx    = ir_q[8 +: RI_W];
    assign b_idx    = ir_q[0 +: RI_W];
    assign rd_val   = rf_q[d_idx];
    assign ra_val   = rf_q[a_idx];
    assign rb_val   = rf_q[b_idx];
    assign addr16   = ir_q[0 +: ADDR_W];
    assign jaddr    = ir_q[8 +: ADDR_W];
    assign pc_next4 = pc_q + ADDR_W'(4);
    // Fetch is MSB first: byte idx lands at bit 8*(3-idx), and 3-idx == ~idx.
    assign byte_lsb = {~idx_q, 3'b000};

    cpu_alu u_alu (
        .op     (opcode),
        .a      (ra_val),
        .b      (rb_val),
        .result (alu_res),
        .z      (alu_z),
        .c      (alu_c)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        z_d         = z_q;
        c_d         = c_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        rf_we       = 1'b0;
        rf_waddr    = d_idx;
        rf_wdata    = alu_res;

        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d[byte_lsb +: 8] = mem_rdata;
                    if (idx_q == 2'd3) begin
                        idx_d     = 2'd0;
                        state_d   = S_DECODE;
                        mem_req_d = 1'b0;
                    end else begin
                        idx_d      = idx_q + 2'd1;
                        mem_addr_d = pc_q + ADDR_W'(idx_q + 2'd1);
                    end
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HALT: begin
                        state_d   = S_HALTED;
                        halted_d  = 1'b1;
                        mem_req_d = 1'b0;
                    end
                    OP_LD, OP_ST: begin
                        state_d     = S_MEM;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = addr16;
                        mem_we_d    = (opcode == OP_ST);
                        mem_wdata_d = (opcode == OP_ST) ? rd_val : 8'h00;
                    end
                    default: state_d = S_EXEC;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (opcode == OP_LD) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    pc_d        = pc_next4;
                    state_d     = S_FETCH;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = pc_next4;
                    mem_we_d    = 1'b0;
                    mem_wdata_d = 8'h00;
                end
            end
            S_EXEC: begin
                pc_d = pc_next4;
                case (opcode)
                    OP_LDI: begin
                        rf_we    = 1'b1;
                        rf_wdata = ir_q[15:8];
                    end
                    OP_MOV: begin
                        rf_we    = 1'b1;
                        rf_wdata = ra_val;
                    end
                    OP_JMP: pc_d = jaddr;
                    OP_JZ:  if (z_q)  pc_d = jaddr;
                    OP_JNZ: if (!z_q) pc_d = jaddr;
                    OP_JC:  if (c_q)  pc_d = jaddr;
                    default: begin
                        if (is_alu_op(opcode)) begin
                            rf_we = 1'b1;
                            z_d   = alu_z;
                            c_d   = alu_c;
                        end
                    end
                endcase
                state_d    = S_FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_d;
            end
            S_HALTED: halted_d = 1'b1;
            default:  state_d  = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            idx_q       <= 2'd0;
            pc_q        <= RV;
            ir_q        <= 32'h0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            mem_req_q   <= 1'b1;
            mem_addr_q  <= RV;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'h00;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            z_q         <= z_d;
            c_q         <= c_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    // Register contents are not reset; only the write strobe is suppressed by rst.
    always_ff @(posedge clk) begin
        if (rf_we && !rst) begin
            rf_q[rf_waddr] <= rf_wdata;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign pc        = pc_q;

endmodule

// File: tb/tb_cpu_mc.sv
// Bench for cpu_mc: ALU/flag vector table, hand-written bus/reset sequences and
// random programs checked against an instruction-level reference model.
module tb_cpu_mc;

    localparam logic [7:0] T_HALT = 8'h00, T_LD  = 8'h01, T_ST  = 8'h02, T_LDI  = 8'h03;
    localparam logic [7:0] T_MOV  = 8'h04, T_ADD = 8'h05, T_SUB = 8'h06, T_AND  = 8'h07;
    localparam logic [7:0] T_OR   = 8'h08, T_XOR = 8'h09, T_ROTL = 8'h0A, T_ROTR = 8'h0B;
    localparam logic [7:0] T_JMP  = 8'h0C, T_JZ  = 8'h0D, T_JNZ = 8'h0E, T_JC   = 8'h0F;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst16, mem_ready, mem_req, mem_we, halted;
    logic [15:0] mem_addr, pc;
    logic [7:0]  mem_rdata, mem_wdata;
    logic        m16_req, m16_we, m16_halted;
    logic [15:0] m16_addr, m16_pc;
    logic [7:0]  m16_rdata, m16_wdata;

    logic [7:0]  mem   [65536];
    logic [7:0]  mem16 [65536];
    logic [7:0]  mmem  [65536];
    logic [7:0]  mr    [256];
    logic [31:0] prog  [$];

    int n_checks;
    int n_err;

    cpu_mc #(.REGS(256), .ADDR_W(16), .RESET_VECTOR(16'h0000)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_req(mem_req),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .halted(halted), .pc(pc)
    );

    cpu_mc #(.REGS(16), .ADDR_W(16), .RESET_VECTOR(16'h0000)) dut16 (
        .clk(clk), .rst(rst16), .mem_addr(m16_addr), .mem_req(m16_req),
        .mem_ready(1'b1), .mem_rdata(m16_rdata), .mem_we(m16_we),
        .mem_wdata(m16_wdata), .halted(m16_halted), .pc(m16_pc)
    );

    assign mem_rdata = mem[mem_addr];
    assign m16_rdata = mem16[m16_addr];

    always @(posedge clk) begin
        if (mem_req === 1'b1 && mem_ready === 1'b1 && mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
        if (m16_req === 1'b1 && m16_we === 1'b1) mem16[m16_addr] <= m16_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] d,
                                        input logic [7:0] a, input logic [7:0] b);
        return {op, d, a, b};
    endfunction

    function automatic logic [31:0] insm(input logic [7:0] op, input logic [7:0] d,
                                         input logic [15:0] addr);
        return {op, d, addr};
    endfunction

    function automatic logic [31:0] insj(input logic [7:0] op, input logic [15:0] t);
        return {op, t, 8'h00};
    endfunction

    // Clears low memory in both the bus model and the reference copy, then places prog at 0.
    task automatic load_prog();
        for (int i = 0; i < 1024; i++) begin
            mem[i]  <= 8'h00;
            mmem[i] = 8'h00;
        end
        for (int i = 0; i < prog.size(); i++) begin
            for (int k = 0; k < 4; k++) begin
                logic [31:0] w;
                logic [7:0]  bv;
                w  = prog[i];
                bv = w[31-8*k -: 8];
                mem[4*i+k]  <= bv;
                mmem[4*i+k] = bv;
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_halt(input int budget, input bit rnd, output int cycles);
        cycles = 0;
        mem_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        while (halted !== 1'b1 && cycles < budget) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (rnd) mem_ready = ($urandom_range(0, 3) != 0);
        end
        mem_ready = 1'b1;
        if (halted !== 1'b1) begin
            n_checks++;
            n_err++;
            $display("FAIL halt timeout: no halt within %0d cycles", budget);
        end
    endtask

    // Instruction-level interpreter over mmem; returns the HALT address and instruction count.
    task automatic model_run(output logic [15:0] fpc, output int n_ins);
        int pc_m, nxt, op, d, a, b, x, y, res;
        bit mz, mc;
        logic [31:0] w;
        pc_m = 0; mz = 0; mc = 0; n_ins = 0; fpc = 16'hFFFF;
        for (int step = 0; step < 2000; step++) begin
            w = {mmem[pc_m], mmem[(pc_m+1)%65536], mmem[(pc_m+2)%65536], mmem[(pc_m+3)%65536]};
            op = int'(w[31:24]); d = int'(w[23:16]); a = int'(w[15:8]); b = int'(w[7:0]);
            if (op == 0) begin
                fpc = 16'(pc_m);
                break;
            end
            n_ins++;
            nxt = (pc_m + 4) % 65536;
            if (op == 1) mr[d] = mmem[w[15:0]];
            else if (op == 2) mmem[w[15:0]] = mr[d];
            else if (op == 3) mr[d] = 8'(a);
            else if (op == 4) mr[d] = mr[a];
            else if (op >= 5 && op <= 11) begin
                x = int'(mr[a]); y = int'(mr[b]); res = 0;
                if (op == 5) begin res = x + y; mc = (res > 255); end
                else if (op == 6) begin res = x - y; mc = (x < y); end
                else begin
                    mc = 0;
                    if (op == 7) res = x & y;
                    else if (op == 8) res = x | y;
                    else if (op == 9) res = x ^ y;
                    else if (op == 10) begin
                        res = x;
                        for (int s = 0; s < y % 8; s++) res = (res * 2) % 256 + res / 128;
                    end else begin
                        res = x;
                        for (int s = 0; s < y % 8; s++) res = res / 2 + (res % 2) * 128;
                    end
                end
                res = ((res % 256) + 256) % 256;
                mz = (res == 0);
                mr[d] = 8'(res);
            end
            else if (op == 12) nxt = int'(w[23:8]);
            else if (op == 13) begin if (mz) nxt = int'(w[23:8]); end
            else if (op == 14) begin if (!mz) nxt = int'(w[23:8]); end
            else if (op == 15) begin if (mc) nxt = int'(w[23:8]); end
            pc_m = nxt;
        end
    endtask

    task automatic gen_rand_prog();
        prog.delete();
        for (int r = 0; r < 8; r++) prog.push_back(ins(T_LDI, 8'(r), 8'($urandom), 8'h00));
        for (int k = 0; k < 16; k++) begin
            int kind, idx;
            logic [7:0] rd, ra, rb;
            idx = 8 + k;
            rd = 8'($urandom_range(0, 7)); ra = 8'($urandom_range(0, 7)); rb = 8'($urandom_range(0, 7));
            kind = $urandom_range(0, 9);
            case (kind)
                0: prog.push_back(ins(T_LDI, rd, 8'($urandom), 8'h00));
                1: prog.push_back(ins(T_MOV, rd, ra, 8'h00));
                5: prog.push_back(insm(T_LD, rd, 16'h0200 + 16'($urandom_range(0, 15))));
                6: prog.push_back(insm(T_ST, rd, 16'h0200 + 16'($urandom_range(0, 15))));
                7: prog.push_back(insj(8'($urandom_range(12, 15)), 16'(4 * $urandom_range(idx + 1, 24))));
                8: prog.push_back(ins(8'($urandom_range(16, 255)), rd, ra, rb));
                default: prog.push_back(ins(8'($urandom_range(5, 11)), rd, ra, rb));
            endcase
        end
        for (int r = 0; r < 8; r++) prog.push_back(insm(T_ST, 8'(r), 16'h0300 + 16'(r)));
        prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
    endtask

    typedef struct {
        logic [7:0] op, a, b, res;
        logic       z, c;
    } alu_vec_t;

    alu_vec_t vecs [13];

    initial begin
        int cyc, cyc2, n_ins, fa;
        logic [15:0] fpc;

        vecs[0]  = '{T_ADD,  8'h7F, 8'h81, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{T_ADD,  8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
        vecs[2]  = '{T_ADD,  8'hFF, 8'h02, 8'h01, 1'b0, 1'b1};
        vecs[3]  = '{T_SUB,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0};
        vecs[4]  = '{T_SUB,  8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
        vecs[5]  = '{T_AND,  8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{T_OR,   8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0};
        vecs[7]  = '{T_XOR,  8'hAA, 8'hAA, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{T_ROTL, 8'h81, 8'h09, 8'h03, 1'b0, 1'b0};
        vecs[9]  = '{T_ROTR, 8'h81, 8'h09, 8'hC0, 1'b0, 1'b0};
        vecs[10] = '{T_ROTL, 8'h5A, 8'h08, 8'h5A, 1'b0, 1'b0};
        vecs[11] = '{T_ROTR, 8'h01, 8'h0F, 8'h02, 1'b0, 1'b0};
        vecs[12] = '{T_SUB,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b1};

        n_checks = 0;
        n_err = 0;
        rst = 1'b1;
        rst16 = 1'b1;
        mem_ready = 1'b1;

        // REGS=16 instance: register index uses only the low 4 bits of each field.
        for (int i = 0; i < 512; i++) mem16[i] <= 8'h00;
        begin
            logic [31:0] p16 [4];
            p16[0] = ins(T_LDI, 8'h13, 8'hAA, 8'h00);
            p16[1] = ins(T_MOV, 8'h00, 8'h23, 8'h00);
            p16[2] = insm(T_ST, 8'h20, 16'h0100);
            p16[3] = ins(T_HALT, 8'h00, 8'h00, 8'h00);
            for (int i = 0; i < 4; i++)
                for (int k = 0; k < 4; k++) mem16[4*i+k] <= p16[i][31-8*k -: 8];
        end

        prog.delete();
        prog.push_back(ins(T_LDI, 8'h01, 8'h7F, 8'h00));
        prog.push_back(ins(T_LDI, 8'h02, 8'h81, 8'h00));
        prog.push_back(ins(T_ADD, 8'h03, 8'h01, 8'h02));
        prog.push_back(insm(T_ST, 8'h03, 16'h0100));
        prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
        load_prog();
        mem[16'h0100] <= 8'hEE;

        @(posedge clk);
        @(negedge clk);
        check("reset mem_req", mem_req, 1);
        check("reset mem_addr", mem_addr, 16'h0000);
        check("reset mem_we", mem_we, 0);
        check("reset mem_wdata", mem_wdata, 0);
        check("reset halted", halted, 0);
        check("reset pc", pc, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        rst16 = 1'b0;

        run_halt(300, 1'b0, cyc);
        check("basic cycles", cyc, 29);
        check("basic pc", pc, 16'h0010);
        check("basic halted", halted, 1);
        check("basic mem_req in halt", mem_req, 0);
        check("basic st result", mem[16'h0100], 8'h00);

        // ALU result and flags; flags are observed through JZ/JC after an LDI in between.
        for (int i = 0; i < 13; i++) begin
            rst = 1'b1;
            prog.delete();
            prog.push_back(ins(T_LDI, 8'h01, vecs[i].a, 8'h00));
            prog.push_back(ins(T_LDI, 8'h02, vecs[i].b, 8'h00));
            prog.push_back(ins(vecs[i].op, 8'h03, 8'h01, 8'h02));
            prog.push_back(insm(T_ST, 8'h03, 16'h0100));
            prog.push_back(ins(T_LDI, 8'h04, 8'h00, 8'h00));
            prog.push_back(insj(T_JZ, 16'h001C));
            prog.push_back(insj(T_JMP, 16'h0020));
            prog.push_back(ins(T_LDI, 8'h04, 8'h01, 8'h00));
            prog.push_back(ins(T_LDI, 8'h05, 8'h00, 8'h00));
            prog.push_back(insj(T_JC, 16'h002C));
            prog.push_back(insj(T_JMP, 16'h0030));
            prog.push_back(ins(T_LDI, 8'h05, 8'h01, 8'h00));
            prog.push_back(insm(T_ST, 8'h04, 16'h0101));
            prog.push_back(insm(T_ST, 8'h05, 16'h0102));
            prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
            load_prog();
            for (int k = 0; k < 3; k++) mem[16'h0100 + k] <= 8'hEE;
            do_reset();
            run_halt(300, 1'b0, cyc);
            check($sformatf("alu%0d result", i), mem[16'h0100], vecs[i].res);
            check($sformatf("alu%0d z", i), mem[16'h0101], 8'(vecs[i].z));
            check($sformatf("alu%0d c", i), mem[16'h0102], 8'(vecs[i].c));
            check($sformatf("alu%0d cycles", i), cyc, 77);
            check($sformatf("alu%0d pc", i), pc, 16'h0038);
        end

        // Count-down loop: five SUB/JNZ iterations then fall through with Z set.
        rst = 1'b1;
        prog.delete();
        prog.push_back(ins(T_LDI, 8'h01, 8'h05, 8'h00));
        prog.push_back(ins(T_LDI, 8'h02, 8'h01, 8'h00));
        prog.push_back(ins(T_SUB, 8'h01, 8'h01, 8'h02));
        prog.push_back(insj(T_JNZ, 16'h0008));
        prog.push_back(insm(T_ST, 8'h01, 16'h0100));
        prog.push_back(ins(T_LDI, 8'h04, 8'h00, 8'h00));
        prog.push_back(insj(T_JZ, 16'h0020));
        prog.push_back(insj(T_JMP, 16'h0024));
        prog.push_back(ins(T_LDI, 8'h04, 8'h01, 8'h00));
        prog.push_back(insm(T_ST, 8'h04, 16'h0101));
        prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
        load_prog();
        mem[16'h0100] <= 8'hEE;
        mem[16'h0101] <= 8'hEE;
        do_reset();
        run_halt(500, 1'b0, cyc);
        check("loop r1", mem[16'h0100], 8'h00);
        check("loop z", mem[16'h0101], 8'h01);
        check("loop cycles", cyc, 107);
        check("loop pc", pc, 16'h0028);

        // Three wait cycles on fetch byte 2 of the first instruction.
        rst = 1'b1;
        prog.delete();
        prog.push_back(ins(T_LDI, 8'h01, 8'h5A, 8'h00));
        prog.push_back(insm(T_ST, 8'h01, 16'h0100));
        prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
        load_prog();
        mem[16'h0100] <= 8'hEE;
        do_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("wait addr before", mem_addr, 16'h0002);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("wait%0d addr held", i), mem_addr, 16'h0002);
            check($sformatf("wait%0d req held", i), mem_req, 1);
        end
        mem_ready = 1'b1;
        run_halt(300, 1'b0, cyc2);
        check("wait total cycles", cyc2 + 5, 20);
        check("wait st result", mem[16'h0100], 8'h5A);

        // Reset while an ST waits in MEM: the write must be abandoned.
        rst = 1'b1;
        prog.delete();
        prog.push_back(ins(T_LDI, 8'h01, 8'h77, 8'h00));
        prog.push_back(insm(T_ST, 8'h01, 16'h0100));
        prog.push_back(ins(T_HALT, 8'h00, 8'h00, 8'h00));
        load_prog();
        mem[16'h0100] <= 8'hEE;
        do_reset();
        repeat (11) @(posedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        check("mem st req", mem_req, 1);
        check("mem st we", mem_we, 1);
        check("mem st addr", mem_addr, 16'h0100);
        check("mem st wdata", mem_wdata, 8'h77);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst mem_req", mem_req, 1);
        check("midrst mem_addr", mem_addr, 16'h0000);
        check("midrst mem_we", mem_we, 0);
        check("midrst mem_wdata", mem_wdata, 0);
        check("midrst halted", halted, 0);
        check("midrst no write", mem[16'h0100], 8'hEE);

        // Random programs against the reference interpreter; odd runs use random wait states.
        for (int t = 0; t < 12; t++) begin
            bit rnd;
            rnd = (t % 2 == 1);
            rst = 1'b1;
            gen_rand_prog();
            load_prog();
            for (int i = 0; i < 16; i++) begin
                logic [7:0] v;
                v = 8'($urandom);
                mem[16'h0200 + i] <= v;
                mmem[16'h0200 + i] = v;
            end
            do_reset();
            model_run(fpc, n_ins);
            run_halt(3000, rnd, cyc);
            check($sformatf("rand%0d pc", t), pc, fpc);
            fa = 16'h0300;
            for (int adr = 16'h0100; adr < 16'h0400; adr++) begin
                if (mem[adr] !== mmem[adr]) begin
                    fa = adr;
                    break;
                end
            end
            check($sformatf("rand%0d mem[%h]", t, fa), mem[fa], mmem[fa]);
            if (!rnd) check($sformatf("rand%0d cycles", t), cyc, 6 * n_ins + 5);
        end

        check("regs16 halted", m16_halted, 1);
        check("regs16 pc", m16_pc, 16'h000C);
        check("regs16 truncated mov", mem16[16'h0100], 8'hAA);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
